// File: rtl/relu_grad_gate.sv
// ReLU backward-pass gate: records the forward positivity mask per neuron and gates upstream gradients.
// Optional macro RELU_GRAD_CNT_EN adds the active_cnt port (positive entries in the last forward pass).
module relu_grad_gate #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          rdy,
    input  logic [31:0]   x_data,
    output logic [31:0]   z_data,
    output logic          done,
    output logic          layer_end,
    output logic          err
`ifdef RELU_GRAD_CNT_EN
    ,
    output logic [AW:0]   active_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        FULL = 2'd2,
        BWD  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    idx;
    logic [DEPTH-1:0] mask;

    logic             pos;
    logic [AW-1:0]    widx;
    logic             fwd_s;
    logic             bwd_s;
    logic             mask_ok;

    // +0 and -0 are not positive; NaN/Inf simply follow the sign bit.
    assign pos     = ~x_data[31] & (x_data[30:0] != '0);
    // A forward sample outside FWD starts a fresh pass at entry 0.
    assign widx    = (state == FWD) ? idx : '0;
    assign fwd_s   = rdy & ~mode;
    assign bwd_s   = rdy & mode;
    assign mask_ok = (state == FULL) || (state == BWD);

`ifdef RELU_GRAD_CNT_EN
    logic [AW:0] run_cnt;
    logic [AW:0] run_next;

    assign run_next = ((state == FWD) ? run_cnt : '0) + (AW+1)'(pos);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt    <= '0;
            active_cnt <= '0;
        end else if (fwd_s) begin
            run_cnt <= run_next;
            if (widx == LAST)
                active_cnt <= run_next;
        end else if (bwd_s && mask_ok && idx == LAST) begin
            active_cnt <= '0;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            // NOTE: the mask is a plain flop vector, so it can be cleared in
            // reset; a real RAM would need a sweep or a valid bit instead.
            mask      <= '0;
            z_data    <= '0;
            done      <= 1'b0;
            layer_end <= 1'b0;
            err       <= 1'b0;
        end else begin
            done      <= 1'b0;
            layer_end <= 1'b0;
            err       <= 1'b0;
            if (fwd_s) begin
                mask[widx] <= pos;
                z_data     <= pos ? x_data : 32'h0;
                done       <= 1'b1;
                if (widx == LAST) begin
                    layer_end <= 1'b1;
                    idx       <= '0;
                    state     <= FULL;
                end else begin
                    idx   <= widx + AW'(1);
                    state <= FWD;
                end
            end else if (bwd_s) begin
                if (mask_ok) begin
                    z_data <= mask[idx] ? x_data : 32'h0;
                    done   <= 1'b1;
                    if (idx == LAST) begin
                        layer_end <= 1'b1;
                        idx       <= '0;
                        state     <= IDLE;
                        mask      <= '0;
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= BWD;
                    end
                end else begin
                    // No complete mask: flag it and leave state, idx and mask alone.
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/relu_grad_gate.md
# relu_grad_gate

Backward-pass companion to the forward `relu` activation in the feedforward datapath. During the forward pass it records, per neuron, whether the IEEE-754 single-precision pre-activation was strictly positive, and emits `relu(x)`. During the backward pass it gates the incoming upstream gradients with that stored mask, producing `dL/dx = g · relu'(x)`. It sits between a layer's pre-activation output and the layer's backprop gradient path, and uses the same `rdy`/`done` handshake as `relu`.

## Interface
Parameters:
- `DEPTH`, 16: neurons per layer, which is also the mask entries; must be ≥2.
- `AW`, 4: index width, with `2^AW ≥ DEPTH`.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = forward (record), 1 = backward (gate); sampled with `rdy`.
- `rdy`  in  1  sample valid; one sample is accepted per cycle in which it is high.
- `x_data`  in  32  forward: pre-activation x; backward: upstream gradient g.
- `z_data`  out  32  forward: relu(x); backward: gated gradient.
- `done`  out  1  one-cycle pulse marking `z_data` valid.
- `layer_end`  out  1  asserted together with `done` for the last (DEPTH-th) sample of a pass.
- `err`  out  1  one-cycle pulse when a backward sample arrives with no valid mask.

## Operation
- States: IDLE (no valid mask), FWD (recording), FULL (mask valid), BWD (gating).
- Positive test: `pos = ~x[31] & (x[30:0] != 0)`. Both +0 and -0 count as not positive. NaN/Inf follow the sign bit.
- Forward sample (`rdy & ~mode`):
  - From IDLE, FULL or BWD: go to FWD, set idx=0, write `mask[0]=pos`.
  - In FWD: write `mask[idx]=pos`.
  - Output `z_data = pos ? x : 32'h0`.
  - After each write, idx++. At idx=DEPTH-1, `layer_end` is raised, idx wraps to 0, and the state goes to FULL.
  - Restarting a forward pass from FULL or BWD discards the old mask. Entries are overwritten in order.
- Backward sample (`rdy & mode`):
  - In FULL or BWD: output `z_data = mask[idx] ? x : 32'h0`, idx++, state BWD.
  - At idx=DEPTH-1: `layer_end`, idx wraps to 0, state goes to IDLE, and the mask is invalidated.
  - In IDLE: pulse `err`; no `done`, and `z_data` holds its value.
  - In FWD (partial mask): pulse `err`; no `done`; state, idx and mask are unchanged.
- The gradient passes through bit-exact. No arithmetic is performed on the data.
- `mode` may change on any accepted sample. Only the transitions above apply.

## Timing
- Reset values: `z_data`=0, `done`=0, `layer_end`=0, `err`=0, idx=0, state=IDLE, mask all 0.
- Latency is 1 cycle. A sample accepted at edge N has `z_data`, `done`, `layer_end` and `err` valid after edge N, for exactly one cycle.
- `z_data` holds its last value when `done` is low.
- Throughput is 1 sample/cycle. `rdy` may be held high continuously.
- No backpressure; `rdy` is never refused.
- `rst` has priority over `rdy` in the same cycle. Reset mid-pass aborts the pass and clears the mask.
- A forward sample arriving in the cycle after the final backward sample starts a new pass cleanly. No bubble is required.

## Configuration
- `RELU_GRAD_CNT_EN` defined:
  - Adds port `active_cnt  out  AW+1`: the number of mask entries set in the last completed forward pass.
  - Updated in the same cycle as the forward `layer_end`.
  - Reset to 0.
  - Held through BWD.
  - Cleared when the backward pass completes.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

## Test plan
- Reset, then a backward sample g=32'h3F800000 → `err` pulse 1 cycle later, no `done`, `z_data`=0.
- Forward pass, DEPTH=16, `rdy` held high, x alternating 1.0 (32'h3F800000) and -1.0 (32'hBF800000):
  - Expected: `z_data` alternates 32'h3F800000/0, 16 `done` pulses, `layer_end` on the 16th.
  - With `RELU_GRAD_CNT_EN`: `active_cnt`=8.
- Backward pass, all g=2.0 (32'h40000000) → `z_data` alternates 32'h40000000/0, `layer_end` on the 16th, then state IDLE, and a further backward sample gives `err`.
- Zero handling: forward x=32'h00000000 and x=32'h80000000, then backward g=1.0 → both gated to 0.
- Backward sample after only 5 forward samples → `err`, no `done`. The forward pass then resumes and completes normally at the 16th sample.
- Assert `rst` during BWD at idx=7 → all outputs 0 the next cycle. A following backward sample gives `err`.
